// File: rtl/weight_stream_ctrl_pkg.sv
// Shared definitions for the weight streaming controller: the pass state
// encoding, the stall-counter width and its saturating increment.
package weight_stream_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } ws_state_e;

   localparam int STALL_CNT_WIDTH = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(input logic [STALL_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + STALL_CNT_WIDTH'(1);
   endfunction

endpackage

// File: rtl/weight_stream_ctrl_pipe_stage.sv
// One pipeline slot: a valid bit plus a data word. The slot only moves on
// cycles where advance is high; otherwise valid and data both hold.
module ws_pipe_stage
   import weight_stream_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             advance,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   // Take the upstream slot on advance; data only loads when it is valid.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (advance) begin
         valid_d = valid_i;
         if (valid_i) begin
            data_d = data_i;
         end
      end
   end

   // Slot register, cleared by the synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/weight_stream_ctrl.sv
// Weight streaming controller: walks a spike list, looks up one weight per
// spike at weightBase+spikeIndex and streams the weights to a neuron.
// Optional build macro WS_STALL_CNT_EN adds the 16-bit stallCount output.
//
// Flow control: readyMem is the neuron's ready. On a cycle with readyMem=1 the
// neuron takes weightData (zero when no weight is valid) and every pipeline
// slot moves one step; with readyMem=0 nothing moves, both memories are left
// unread (they hold their outputs) and weightData is forced to zero.
module weight_stream_ctrl
   import weight_stream_ctrl_pkg::*;
#(
   parameter int FRACTION_WIDTH = 8,
   parameter int DATA_WIDTH     = 16,
   parameter int IDX_WIDTH      = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [IDX_WIDTH-1:0]      spikeCount,
   input  logic [IDX_WIDTH-1:0]      weightBase,
   input  logic [DATA_WIDTH-1:0]     vmemLoad,
   input  logic                      readyMem,
   output logic [IDX_WIDTH-1:0]      spkAddr,
   output logic                      spkRdEn,
   input  logic [IDX_WIDTH-1:0]      spkData,
   output logic [IDX_WIDTH-1:0]      wAddr,
   output logic                      wRdEn,
   input  logic [FRACTION_WIDTH-1:0] wData,
   output logic [FRACTION_WIDTH-1:0] weightData,
   output logic [DATA_WIDTH-1:0]     vmemIn,
   output logic                      finished,
   output logic                      busy
`ifdef WS_STALL_CNT_EN
   ,
   output logic [STALL_CNT_WIDTH-1:0] stallCount
`endif
);

   ws_state_e            state_q, state_d;
   logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
   logic [IDX_WIDTH-1:0] count_q, count_d;
   logic [IDX_WIDTH-1:0] base_q, base_d;
   logic [DATA_WIDTH-1:0] vmem_q, vmem_d;

   logic                      fetching;
   logic                      accept;
   logic                      pipe_empty;
   logic                      s1_valid, s2_valid, s3_valid;
   logic                      s1_data, s2_data;
   logic [FRACTION_WIDTH-1:0] s3_data;

   assign fetching   = (state_q == FETCH);
   assign accept     = ((state_q == IDLE) || (state_q == DONE)) && start;
   assign pipe_empty = !s1_valid && !s2_valid && !s3_valid;

   // Pass sequencing: latch the job on start, issue list entries, drain, finish.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      base_d  = base_q;
      vmem_d  = vmem_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               vmem_d  = vmemLoad;
               count_d = spikeCount;
               base_d  = weightBase;
               ptr_d   = '0;
               state_d = (spikeCount == '0) ? DRAIN : FETCH;
            end
         end
         FETCH: begin
            if (readyMem) begin
               ptr_d = ptr_q + IDX_WIDTH'(1);
               if (ptr_d == count_q) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pipe_empty) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers; reset returns everything to an empty idle controller.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         count_q <= '0;
         base_q  <= '0;
         vmem_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         base_q  <= base_d;
         vmem_q  <= vmem_d;
      end
   end

   // Stage 1: the spike-list read issued last cycle, spkData now valid.
   ws_pipe_stage #(.WIDTH(1)) u_stage_spk (
      .clk     (clk),
      .reset   (reset),
      .advance (readyMem),
      .valid_i (fetching),
      .data_i  (1'b0),
      .valid_o (s1_valid),
      .data_o  (s1_data)
   );

   // Stage 2: the weight read issued last cycle, wData now valid.
   ws_pipe_stage #(.WIDTH(1)) u_stage_wgt (
      .clk     (clk),
      .reset   (reset),
      .advance (readyMem),
      .valid_i (s1_valid),
      .data_i  (1'b0),
      .valid_o (s2_valid),
      .data_o  (s2_data)
   );

   // Stage 3: the weight register presented to the neuron.
   ws_pipe_stage #(.WIDTH(FRACTION_WIDTH)) u_stage_out (
      .clk     (clk),
      .reset   (reset),
      .advance (readyMem),
      .valid_i (s2_valid),
      .data_i  (wData),
      .valid_o (s3_valid),
      .data_o  (s3_data)
   );

   // Stages 1 and 2 only track validity; the memories hold the data itself.
   logic unused_stage_data;
   assign unused_stage_data = s1_data ^ s2_data;

   assign spkAddr    = ptr_q;
   assign spkRdEn    = fetching && readyMem;
   assign wRdEn      = s1_valid && readyMem;
   assign wAddr      = s1_valid ? (base_q + spkData) : '0;
   assign weightData = (s3_valid && readyMem) ? s3_data : '0;
   assign vmemIn     = vmem_q;
   assign finished   = (state_q == DONE);
   assign busy       = (state_q == FETCH) || (state_q == DRAIN);

`ifdef WS_STALL_CNT_EN
   logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

   // Count busy cycles where the neuron held off; restart with each new pass.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (accept) begin
         stall_cnt_d = '0;
      end else if (busy && !readyMem) begin
         stall_cnt_d = sat_inc(stall_cnt_q);
      end
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stallCount = stall_cnt_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Bench for weight_stream_ctrl: behavioural spike-list and weight memories,
// a weight scoreboard fed when each pass is launched, directed passes and
// one randomised pass.
module tb_weight_stream_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [9:0]  spikeCount;
   logic [9:0]  weightBase;
   logic [15:0] vmemLoad;
   logic        readyMem;
   logic [9:0]  spkAddr;
   logic        spkRdEn;
   logic [9:0]  spkData = '0;
   logic [9:0]  wAddr;
   logic        wRdEn;
   logic [7:0]  wData = '0;
   logic [7:0]  weightData;
   logic [15:0] vmemIn;
   logic        finished;
   logic        busy;
`ifdef WS_STALL_CNT_EN
   logic [15:0] stallCount;
`endif

   weight_stream_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .spikeCount (spikeCount),
      .weightBase (weightBase),
      .vmemLoad   (vmemLoad),
      .readyMem   (readyMem),
      .spkAddr    (spkAddr),
      .spkRdEn    (spkRdEn),
      .spkData    (spkData),
      .wAddr      (wAddr),
      .wRdEn      (wRdEn),
      .wData      (wData),
      .weightData (weightData),
      .vmemIn     (vmemIn),
      .finished   (finished),
      .busy       (busy)
`ifdef WS_STALL_CNT_EN
      ,
      .stallCount (stallCount)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- memory models ----------------
   logic [9:0] spk_mem [0:1023];
   logic [9:0] lst [0:7];

   // One-cycle-latency reads that hold their output when not enabled.
   always @(posedge clk) begin
      if (spkRdEn) spkData <= spk_mem[spkAddr];
      if (wRdEn)   wData   <= wAddr[7:0];
   end

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every non-zero weight the neuron consumes must be the next expected one.
   always @(negedge clk) begin
      if (reset) begin
         if (!readyMem) begin
            check_eq("stall_zero", 32'(weightData), 0);
         end else if (weightData != 0) begin
            if (exp_q.size() == 0) check_eq("weight_unexpected", 32'(weightData), 0);
            else                   check_eq("weight_order", 32'(weightData), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_and_push(input int n, input logic [9:0] base);
      logic [9:0] a;
      for (int k = 0; k < n; k++) begin
         spk_mem[k] = lst[k];
         a = base + lst[k];
         exp_q.push_back(a[7:0]);
      end
   endtask

   // Returns #1 into the first cycle after the start edge.
   task automatic start_pass(input int n, input logic [9:0] base, input logic [15:0] vm, input bit hold);
      @(posedge clk); #1;
      spikeCount = 10'(n);
      weightBase = base;
      vmemLoad   = vm;
      start      = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
   endtask

   int obs_addr0, obs_first, obs_last, obs_fin, obs_rd, obs_w, obs_waddr;

   // Runs cycles until finished, driving readyMem and recording pass events.
   task automatic observe_pass(input int limit, input int stall_a, input int stall_b, input bit rnd);
      obs_addr0 = -1; obs_first = -1; obs_last = -1; obs_fin = -1;
      obs_rd = 0; obs_w = 0; obs_waddr = -1;
      for (int c = 1; c <= limit; c++) begin
         if (rnd) readyMem = ($urandom_range(0, 3) != 0);
         else     readyMem = !(c == stall_a || c == stall_b);
         @(negedge clk);
         if (spkRdEn) begin
            obs_rd++;
            if (obs_addr0 < 0 && spkAddr == 0) obs_addr0 = c;
         end
         if (wRdEn && obs_waddr < 0) obs_waddr = int'(wAddr);
         if (weightData != 0) begin
            if (obs_first < 0) obs_first = c;
            obs_last = c;
            obs_w++;
         end
         if (finished) begin
            obs_fin = c;
            break;
         end
         @(posedge clk); #1;
      end
      readyMem = 1'b1;
      if (obs_fin < 0) check_eq("finish_timeout", 0, 1);
   endtask

   task automatic check_idle_zero(input string pfx);
      check_eq({pfx, "_weightData"}, 32'(weightData), 0);
      check_eq({pfx, "_vmemIn"},     32'(vmemIn), 0);
      check_eq({pfx, "_spkAddr"},    32'(spkAddr), 0);
      check_eq({pfx, "_wAddr"},      32'(wAddr), 0);
      check_eq({pfx, "_spkRdEn"},    32'(spkRdEn), 0);
      check_eq({pfx, "_wRdEn"},      32'(wRdEn), 0);
      check_eq({pfx, "_finished"},   32'(finished), 0);
      check_eq({pfx, "_busy"},       32'(busy), 0);
      check_eq({pfx, "_state"},      32'(dut.state_q), 0);
`ifdef WS_STALL_CNT_EN
      check_eq({pfx, "_stallCount"}, 32'(stallCount), 0);
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      logic [9:0] rbase;
      for (int i = 0; i < 1024; i++) spk_mem[i] = '0;
      reset = 1'b0; start = 1'b0; readyMem = 1'b1;
      spikeCount = '0; weightBase = '0; vmemLoad = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_zero("por");
      @(posedge clk); #1;
      reset = 1'b1;

      // Basic pass, no stalls: latency 3, back-to-back weights.
      lst[0] = 10'd3; lst[1] = 10'd7; lst[2] = 10'd1; lst[3] = 10'd9;
      load_and_push(4, 10'd100);
      start_pass(4, 10'd100, 16'h0042, 1'b0);
      observe_pass(40, 0, 0, 1'b0);
      check_eq("p1_latency",   32'(obs_first - obs_addr0), 3);
      check_eq("p1_no_bubble", 32'(obs_last - obs_first), 3);
      check_eq("p1_wcount",    32'(obs_w), 4);
      check_eq("p1_rdcount",   32'(obs_rd), 4);
      check_eq("p1_waddr0",    32'(obs_waddr), 103);
      check_eq("p1_fin_delay", 32'(obs_fin - obs_last), 2);
      check_eq("p1_done_busy", 32'(busy), 0);
      check_eq("p1_vmemIn",    32'(vmemIn), 32'h0042);
      check_eq("p1_sb_empty",  32'(exp_q.size()), 0);

      // Same list with a 2-cycle stall right after the second weight.
      load_and_push(4, 10'd100);
      start_pass(4, 10'd100, 16'h0042, 1'b0);
      observe_pass(40, 6, 7, 1'b0);
      check_eq("p2_latency",  32'(obs_first - obs_addr0), 3);
      check_eq("p2_span",     32'(obs_last - obs_first), 5);
      check_eq("p2_wcount",   32'(obs_w), 4);
      check_eq("p2_sb_empty", 32'(exp_q.size()), 0);
`ifdef WS_STALL_CNT_EN
      check_eq("p2_stallCount", 32'(stallCount), 2);
`endif

      // Empty spike list.
      start_pass(0, 10'd100, 16'h0180, 1'b0);
      observe_pass(10, 0, 0, 1'b0);
      check_eq("p3_rdcount",   32'(obs_rd), 0);
      check_eq("p3_wcount",    32'(obs_w), 0);
      check_eq("p3_fin_by_2",  32'(obs_fin >= 1 && obs_fin <= 2), 1);
      check_eq("p3_vmemIn",    32'(vmemIn), 32'h0180);

      // Reset in the middle of FETCH, then a clean pass.
      start_pass(4, 10'd100, 16'h0BEE, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_idle_zero("mid_rst");
      @(posedge clk); #1;
      reset = 1'b1;
      lst[0] = 10'd2; lst[1] = 10'd4; lst[2] = 10'd6; lst[3] = 10'd8; lst[4] = 10'd10;
      load_and_push(5, 10'd50);
      start_pass(5, 10'd50, 16'h1234, 1'b0);
      observe_pass(40, 0, 0, 1'b0);
      check_eq("p4_latency",  32'(obs_first - obs_addr0), 3);
      check_eq("p4_wcount",   32'(obs_w), 5);
      check_eq("p4_rdcount",  32'(obs_rd), 5);
      check_eq("p4_waddr0",   32'(obs_waddr), 52);
      check_eq("p4_vmemIn",   32'(vmemIn), 32'h1234);
      check_eq("p4_sb_empty", 32'(exp_q.size()), 0);

      // start held high: no restart mid-pass, re-accepted after DONE.
      lst[0] = 10'd11; lst[1] = 10'd22; lst[2] = 10'd33; lst[3] = 10'd44;
      load_and_push(4, 10'd200);
      start_pass(4, 10'd200, 16'h0A5A, 1'b1);
      vmemLoad = 16'h7777;
      observe_pass(40, 0, 0, 1'b0);
      check_eq("p5_rdcount",   32'(obs_rd), 4);
      check_eq("p5_wcount",    32'(obs_w), 4);
      check_eq("p5_vmem_hold", 32'(vmemIn), 32'h0A5A);
      load_and_push(4, 10'd200);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_eq("p5_fin_drop",   32'(finished), 0);
      check_eq("p5_busy_again", 32'(busy), 1);
      check_eq("p5_vmem_new",   32'(vmemIn), 32'h7777);
      @(posedge clk); #1;
      observe_pass(40, 0, 0, 1'b0);
      check_eq("p5b_wcount",   32'(obs_w), 4);
      check_eq("p5b_sb_empty", 32'(exp_q.size()), 0);

      // Weight address wraps modulo 2^10.
      lst[0] = 10'd5;
      load_and_push(1, 10'h3FE);
      start_pass(1, 10'h3FE, 16'h0001, 1'b0);
      observe_pass(20, 0, 0, 1'b0);
      check_eq("p6_wrap_waddr", 32'(obs_waddr), 32'h003);
      check_eq("p6_wcount",     32'(obs_w), 1);

      // Randomised list with random neuron back-pressure.
      n = $urandom_range(1, 8);
      rbase = 10'($urandom_range(1, 100));
      for (int k = 0; k < n; k++) lst[k] = 10'($urandom_range(1, 50));
      load_and_push(n, rbase);
      start_pass(n, rbase, 16'($urandom_range(1, 65535)), 1'b0);
      observe_pass(200, 0, 0, 1'b1);
      check_eq("rnd_rdcount",  32'(obs_rd), 32'(n));
      check_eq("rnd_wcount",   32'(obs_w), 32'(n));
      check_eq("rnd_sb_empty", 32'(exp_q.size()), 0);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
